// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM access arbiter: FSM state encodings,
// requester IDs, default SRAM base addresses and the address-mapping helper.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      WRITE   = 2'd2,
      RECOVER = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_PPU = 1'b1
   } req_id_t;

   localparam logic [17:0] DEF_PATTERN_START = 18'd0;
   localparam logic [17:0] DEF_PROGRAM_START = 18'd0;

   // Base + zero-extended offset, silently wrapping modulo 2^18.
   function automatic logic [17:0] sram_map(input logic [17:0] base, input logic [15:0] offs);
      return base + {2'b00, offs};
   endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: CPU read/write channel, PPU read
// channel and the CPU ready flag. The arbiter takes the slave modport.
interface sram_access_arbiter_if;
   logic        cpu_req;
   logic        cpu_rnw;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        ready;
   logic        ppu_req;
   logic [12:0] ppu_addr;
   logic        ppu_ack;
   logic [7:0]  ppu_rdata;

   modport master (
      output cpu_req, cpu_rnw, cpu_addr, cpu_wdata, ppu_req, ppu_addr,
      input  cpu_ack, cpu_rdata, ready, ppu_ack, ppu_rdata
   );

   modport slave (
      input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata, ppu_req, ppu_addr,
      output cpu_ack, cpu_rdata, ready, ppu_ack, ppu_rdata
   );
endinterface

// File: rtl/sram_grant_policy.sv
// Priority decision for the SRAM arbiter: PPU first, CPU forced through once
// it has watched CPU_MAX_WAIT consecutive PPU grants. Owns the wait counter.
module sram_grant_policy #(
   parameter int CPU_MAX_WAIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       idle,
   input  logic       cpu_req,
   input  logic       ppu_req,
   output logic       grant_cpu,
   output logic       grant_ppu,
   output logic [3:0] wait_cnt
);

   localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

   always_comb begin
      grant_cpu = 1'b0;
      grant_ppu = 1'b0;
      if (idle) begin
         if (cpu_req && (wait_cnt >= MAX_WAIT)) begin
            grant_cpu = 1'b1;
         end else if (ppu_req) begin
            grant_ppu = 1'b1;
         end else if (cpu_req) begin
            grant_cpu = 1'b1;
         end
      end
   end

   // Only IDLE cycles move the counter; it saturates rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= 4'd0;
      end else if (idle) begin
         if (!cpu_req || grant_cpu) begin
            wait_cnt <= 4'd0;
         end else if (grant_ppu && (wait_cnt != 4'd15)) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one external 8-bit SRAM between CPU (read/write) and PPU (read-only).
// Optional macro SRAM_WRITE_PROTECT_EN drops CPU writes to $8000-$FFFF.
//
// state   | meaning
// IDLE    | strobes high, arbitrate every cycle
// READ    | csn/oen low for ACCESS_CYCLES cycles, capture sram_din on the last
// WRITE   | csn/wen low, bus driven with cpu_wdata for ACCESS_CYCLES cycles
// RECOVER | one turnaround cycle, ack visible here
module sram_access_arbiter
   import mem_pkg::*;
#(
   parameter logic [17:0] SRAM_PATTERN_START = DEF_PATTERN_START,
   parameter logic [17:0] SRAM_PROGRAM_START = DEF_PROGRAM_START,
   parameter int          ACCESS_CYCLES      = 2,
   parameter int          CPU_MAX_WAIT       = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   sram_access_arbiter_if.slave bus,
   output logic                 sram_csn,
   output logic                 sram_oen,
   output logic                 sram_wen,
   output logic [17:0]          sram_addr,
   output logic [7:0]           sram_dout,
   output logic [7:0]           sram_data_t,
   input  logic [7:0]           sram_din
);

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   arb_state_t  state_q, state_d;
   req_id_t     owner_q, owner_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [17:0] addr_d;
   logic [7:0]  dout_d;
   logic [7:0]  cpu_rdata_d, ppu_rdata_d;
   logic        cpu_ack_d, ppu_ack_d;
   logic        grant_cpu, grant_ppu;
   logic        wp_block;
   logic [3:0]  wait_cnt;

`ifdef SRAM_WRITE_PROTECT_EN
   assign wp_block = bus.cpu_addr[15];
`else
   assign wp_block = 1'b0;
`endif

   sram_grant_policy #(
      .CPU_MAX_WAIT (CPU_MAX_WAIT)
   ) u_policy (
      .clk       (clk),
      .rst       (rst),
      .idle      (state_q == IDLE),
      .cpu_req   (bus.cpu_req),
      .ppu_req   (bus.ppu_req),
      .grant_cpu (grant_cpu),
      .grant_ppu (grant_ppu),
      .wait_cnt  (wait_cnt)
   );

   assign bus.ready = ~(bus.cpu_req & bus.cpu_rnw & ~bus.cpu_ack);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      addr_d      = sram_addr;
      dout_d      = sram_dout;
      cpu_rdata_d = bus.cpu_rdata;
      ppu_rdata_d = bus.ppu_rdata;
      cpu_ack_d   = 1'b0;
      ppu_ack_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_ppu) begin
               owner_d = REQ_PPU;
               addr_d  = sram_map(SRAM_PATTERN_START, {3'b000, bus.ppu_addr});
               cnt_d   = CNT_LOAD;
               state_d = READ;
            end else if (grant_cpu) begin
               owner_d = REQ_CPU;
               cnt_d   = CNT_LOAD;
               if (bus.cpu_rnw) begin
                  addr_d  = sram_map(SRAM_PROGRAM_START, bus.cpu_addr);
                  state_d = READ;
               end else if (wp_block) begin
                  // Protected write: acknowledged without touching the pins.
                  cpu_ack_d = 1'b1;
                  state_d   = RECOVER;
               end else begin
                  addr_d  = sram_map(SRAM_PROGRAM_START, bus.cpu_addr);
                  dout_d  = bus.cpu_wdata;
                  state_d = WRITE;
               end
            end
         end
         READ, WRITE: begin
            if (cnt_q == 4'd0) begin
               state_d = RECOVER;
               if (owner_q == REQ_PPU) begin
                  ppu_ack_d = 1'b1;
                  if (state_q == READ) ppu_rdata_d = sram_din;
               end else begin
                  cpu_ack_d = 1'b1;
                  if (state_q == READ) cpu_rdata_d = sram_din;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pin registers follow the next state so strobes line up with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_q       <= REQ_CPU;
         cnt_q         <= 4'd0;
         sram_csn      <= 1'b1;
         sram_oen      <= 1'b1;
         sram_wen      <= 1'b1;
         sram_data_t   <= 8'hFF;
         sram_addr     <= 18'd0;
         sram_dout     <= 8'd0;
         bus.cpu_ack   <= 1'b0;
         bus.ppu_ack   <= 1'b0;
         bus.cpu_rdata <= 8'd0;
         bus.ppu_rdata <= 8'd0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         cnt_q         <= cnt_d;
         sram_csn      <= !((state_d == READ) || (state_d == WRITE));
         sram_oen      <= (state_d != READ);
         sram_wen      <= (state_d != WRITE);
         sram_data_t   <= (state_d == WRITE) ? 8'h00 : 8'hFF;
         sram_addr     <= addr_d;
         sram_dout     <= dout_d;
         bus.cpu_ack   <= cpu_ack_d;
         bus.ppu_ack   <= ppu_ack_d;
         bus.cpu_rdata <= cpu_rdata_d;
         bus.ppu_rdata <= ppu_rdata_d;
      end
   end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: vector table of single accesses plus
// hand sequences for contention, starvation bound, reset abort and write protect.
module tb_sram_access_arbiter;

   logic        clk;
   logic        rst;
   logic        sram_csn, sram_oen, sram_wen;
   logic [17:0] sram_addr;
   logic [7:0]  sram_dout, sram_data_t, sram_din;
   logic [7:0]  mem [0:262143];

   int tests = 0;
   int fails = 0;

   sram_access_arbiter_if bus ();

   sram_access_arbiter #(
      .SRAM_PATTERN_START (18'h10000),
      .SRAM_PROGRAM_START (18'h3F000),
      .ACCESS_CYCLES      (2),
      .CPU_MAX_WAIT       (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .sram_csn    (sram_csn),
      .sram_oen    (sram_oen),
      .sram_wen    (sram_wen),
      .sram_addr   (sram_addr),
      .sram_dout   (sram_dout),
      .sram_data_t (sram_data_t),
      .sram_din    (sram_din)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign sram_din = mem[sram_addr];
   always @(posedge clk) begin
      if (!sram_csn && !sram_wen) mem[sram_addr] = sram_dout;
   end

   typedef struct {
      bit          cpu;
      bit          rnw;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [17:0] exp_addr;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat = 0;
      int strb = 0;
      int bad_addr = 0;
      int bad_ready = 0;
      int bad_wr = 0;
      bit got = 0;
      bit rec_ok = 0;
      logic [7:0] rd = 8'h00;
      logic ack;
      if (v.cpu) begin
         bus.cpu_req = 1'b1; bus.cpu_rnw = v.rnw; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
      end else begin
         bus.ppu_req = 1'b1; bus.ppu_addr = v.addr[12:0];
      end
      for (int c = 1; c <= 12 && !got; c++) begin
         @(negedge clk);
         ack = v.cpu ? bus.cpu_ack : bus.ppu_ack;
         if (v.rnw ? !sram_oen : !sram_wen) begin
            strb++;
            if (sram_addr !== v.exp_addr) bad_addr++;
            if (!v.rnw && (sram_data_t !== 8'h00 || sram_dout !== v.wdata)) bad_wr++;
         end
         if (bus.ready !== !(v.cpu && v.rnw && !ack)) bad_ready++;
         if (ack) begin
            got = 1; lat = c;
            rd = v.cpu ? bus.cpu_rdata : bus.ppu_rdata;
            rec_ok = sram_csn && sram_oen && sram_wen && (sram_data_t == 8'hFF);
            bus.cpu_req = 1'b0; bus.ppu_req = 1'b0;
         end
      end
      chk($sformatf("v%0d_latency", idx), lat, 3);
      chk($sformatf("v%0d_strobe_cycles", idx), strb, 2);
      chk($sformatf("v%0d_addr", idx), bad_addr, 0);
      chk($sformatf("v%0d_ready", idx), bad_ready, 0);
      chk($sformatf("v%0d_recover", idx), {31'd0, rec_ok}, 1);
      if (v.rnw) chk($sformatf("v%0d_rdata", idx), rd, v.exp_data);
      else begin
         chk($sformatf("v%0d_wr_bus", idx), bad_wr, 0);
         chk($sformatf("v%0d_mem", idx), mem[v.exp_addr], v.exp_data);
      end
      @(negedge clk);
   endtask

   initial begin
      int ppu_acks, cpu_cyc, ppu_cyc, maxw, bad_ready, csn_cyc;
      logic [3:0] wait_at_ack;
      logic [7:0] rd;

      for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
      mem[18'h10123] = 8'hA5;
      mem[18'h11FFF] = 8'h5A;
      mem[18'h0EFFF] = 8'hC3;
      mem[18'h07000] = 8'h11;
      mem[18'h10456] = 8'h77;
      mem[18'h3F010] = 8'h2B;
      mem[18'h0B000] = 8'hE1;

      vecs[0] = '{1'b0, 1'b1, 16'h0123, 8'h00, 18'h10123, 8'hA5};
      vecs[1] = '{1'b0, 1'b1, 16'h1FFF, 8'h00, 18'h11FFF, 8'h5A};
      vecs[2] = '{1'b1, 1'b0, 16'h0200, 8'h3C, 18'h3F200, 8'h3C};
      vecs[3] = '{1'b1, 1'b1, 16'h0200, 8'h00, 18'h3F200, 8'h3C};
      vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 8'h00, 18'h0EFFF, 8'hC3};
      vecs[5] = '{1'b1, 1'b0, 16'h7FFF, 8'h99, 18'h06FFF, 8'h99};
      vecs[6] = '{1'b1, 1'b1, 16'h7FFF, 8'h00, 18'h06FFF, 8'h99};
      vecs[7] = '{1'b1, 1'b1, 16'h8000, 8'h00, 18'h07000, 8'h11};

      rst = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_rnw = 1'b1; bus.cpu_addr = 16'h0; bus.cpu_wdata = 8'h0;
      bus.ppu_req = 1'b0; bus.ppu_addr = 13'h0;
      repeat (3) @(negedge clk);
      chk("rst_strobes", {sram_csn, sram_oen, sram_wen}, 3'b111);
      chk("rst_data_t", sram_data_t, 8'hFF);
      chk("rst_addr", sram_addr, 18'd0);
      chk("rst_dout", sram_dout, 8'd0);
      chk("rst_acks", {bus.cpu_ack, bus.ppu_ack}, 2'b00);
      chk("rst_rdata", {bus.cpu_rdata, bus.ppu_rdata}, 16'h0000);
      chk("rst_ready", bus.ready, 1'b1);
      chk("rst_wait", dut.u_policy.wait_cnt, 4'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Simultaneous CPU read and PPU read: PPU first, CPU one slot later.
      bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 16'h8000;
      bus.ppu_req = 1'b1; bus.ppu_addr = 13'h0456;
      ppu_cyc = 0; cpu_cyc = 0; bad_ready = 0;
      for (int c = 1; c <= 20 && cpu_cyc == 0; c++) begin
         @(negedge clk);
         if (bus.ready !== bus.cpu_ack) bad_ready++;
         if (bus.ppu_ack) begin ppu_cyc = c; bus.ppu_req = 1'b0; end
         if (bus.cpu_ack) begin cpu_cyc = c; bus.cpu_req = 1'b0; end
      end
      chk("sim_ppu_ack_cycle", ppu_cyc, 3);
      chk("sim_cpu_ack_cycle", cpu_cyc, 7);
      chk("sim_ready", bad_ready, 0);
      chk("sim_cpu_rdata", bus.cpu_rdata, 8'h11);
      chk("sim_ppu_rdata_held", bus.ppu_rdata, 8'h77);
      @(negedge clk);

      // Starvation bound: PPU held high continuously against a pending CPU read.
      bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 16'h0010;
      bus.ppu_req = 1'b1; bus.ppu_addr = 13'h0000;
      ppu_acks = 0; cpu_cyc = 0; maxw = 0; wait_at_ack = 4'hF; rd = 8'h00;
      for (int c = 1; c <= 60 && cpu_cyc == 0; c++) begin
         @(negedge clk);
         if (bus.ppu_ack) ppu_acks++;
         if (int'(dut.u_policy.wait_cnt) > maxw) maxw = int'(dut.u_policy.wait_cnt);
         if (bus.cpu_ack) begin
            cpu_cyc = c; rd = bus.cpu_rdata; wait_at_ack = dut.u_policy.wait_cnt;
            bus.cpu_req = 1'b0; bus.ppu_req = 1'b0;
         end
      end
      chk("starve_ppu_acks", ppu_acks, 4);
      chk("starve_cpu_ack_cycle", cpu_cyc, 19);
      chk("starve_max_wait", maxw, 4);
      chk("starve_wait_cleared", wait_at_ack, 4'd0);
      chk("starve_cpu_rdata", rd, 8'h2B);
      @(negedge clk);

      // Reset during READ aborts the access; the held request is served again.
      bus.ppu_req = 1'b1; bus.ppu_addr = 13'h0123;
      @(negedge clk);
      chk("rstmid_in_read", sram_oen, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_strobes", {sram_csn, sram_oen, sram_wen}, 3'b111);
      chk("rstmid_data_t", sram_data_t, 8'hFF);
      chk("rstmid_no_ack", bus.ppu_ack, 1'b0);
      rst = 1'b0;
      ppu_cyc = 0;
      for (int c = 1; c <= 12 && ppu_cyc == 0; c++) begin
         @(negedge clk);
         if (bus.ppu_ack) begin ppu_cyc = c; bus.ppu_req = 1'b0; end
      end
      chk("rstmid_reserve_cycle", ppu_cyc, 3);
      chk("rstmid_rdata", bus.ppu_rdata, 8'hA5);
      @(negedge clk);

      // CPU write into $C000 (PRG ROM space).
      bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_addr = 16'hC000; bus.cpu_wdata = 8'h55;
      cpu_cyc = 0; csn_cyc = 0;
      for (int c = 1; c <= 12 && cpu_cyc == 0; c++) begin
         @(negedge clk);
         if (!sram_csn) csn_cyc++;
         if (bus.cpu_ack) begin cpu_cyc = c; bus.cpu_req = 1'b0; end
      end
      @(negedge clk);
`ifdef SRAM_WRITE_PROTECT_EN
      chk("wp_ack_cycle", cpu_cyc, 1);
      chk("wp_csn_cycles", csn_cyc, 0);
      chk("wp_mem_unchanged", mem[18'h0B000], 8'hE1);
`else
      chk("rom_wr_ack_cycle", cpu_cyc, 3);
      chk("rom_wr_csn_cycles", csn_cyc, 2);
      chk("rom_wr_mem", mem[18'h0B000], 8'h55);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
